hilo_mult_unit: RTL and testbench

Multiply-side control stage for the pipelined MIPS datapath. Sits between the EX stage and the combinational signed multiplier: registers operands into the multiplier, pipelines its 2*WL product over LAT cycles, and commits the result to the architectural HI/LO registers. Also services MTHI/MTLO and exposes a busy/stall signal so hazard logic can hold MFHI/MFLO until HI/LO are valid.

---
 rtl/hilo_mult_unit.sv | 119 +++++++++++
 tb/tb_hilo_mult_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_unit.sv
// HI/LO multiply control: MULT/MADD commit LAT edges after accept, MTHI/MTLO write in one edge.
// op_ready drops while busy or flushed; HILO_MADD_EN enables the op 11 accumulate path.
module hilo_mult_unit #(
  parameter int WL  = 32,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  input  logic [1:0]      op_code,
  input  logic [WL-1:0]   op_a,
  input  logic [WL-1:0]   op_b,
  input  logic            flush,
  output logic            op_ready,
  output logic [WL-1:0]   mul_a,
  output logic [WL-1:0]   mul_b,
  input  logic [2*WL-1:0] mul_prod,
  output logic [WL-1:0]   hi,
  output logic [WL-1:0]   lo,
  output logic            busy,
  output logic            done
);
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*WL-1:0] final_prod;
  logic            accept;
  logic            start_mul;
`ifdef HILO_MADD_EN
  logic            is_madd;
`endif

  assign op_ready = ~busy & ~flush;
  assign accept   = op_valid & op_ready;

`ifdef HILO_MADD_EN
  assign start_mul = accept & ((op_code == 2'b00) | (op_code == 2'b11));
`else
  assign start_mul = accept & (op_code == 2'b00);
`endif

  // Product stages only advance in RUN; a flush simply never consumes them.
  generate
    if (LAT == 1) begin : g_direct
      assign final_prod = mul_prod;
    end else begin : g_pipe
      logic [2*WL-1:0] pipe [LAT-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
        end else if (state == RUN) begin
          pipe[0] <= mul_prod;
          for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign final_prod = pipe[LAT-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef HILO_MADD_EN
      is_madd <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mul) begin
            mul_a   <= op_a;
            mul_b   <= op_b;
            cnt     <= CW'(LAT);
            state   <= RUN;
            busy    <= 1'b1;
`ifdef HILO_MADD_EN
            is_madd <= (op_code == 2'b11);
`endif
          end else if (accept && op_code == 2'b01) begin
            hi <= op_a;
          end else if (accept && op_code == 2'b10) begin
            lo <= op_a;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CW'(1)) begin
`ifdef HILO_MADD_EN
            if (is_madd) {hi, lo} <= {hi, lo} + final_prod;
            else         {hi, lo} <= final_prod;
`else
            {hi, lo} <= final_prod;
`endif
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_mult_unit.sv
// Bench for hilo_mult_unit: directed timing steps plus random ops against an arithmetic HI/LO model.
module tb_hilo_mult_unit;
  localparam int WL  = 32;
  localparam int LAT = 2;
`ifdef HILO_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            op_valid;
  logic [1:0]      op_code;
  logic [WL-1:0]   op_a, op_b;
  logic            flush;
  logic            op_ready;
  logic [WL-1:0]   mul_a, mul_b;
  logic [2*WL-1:0] mul_prod;
  logic [WL-1:0]   hi, lo;
  logic            busy, done;

  int n_chk  = 0;
  int n_fail = 0;
  string cur = "init";
  logic [WL-1:0] m_hi, m_lo;

  always #5 clk = ~clk;

  // Environment: the combinational signed multiplier the unit drives.
  assign mul_prod = longint'($signed(mul_a)) * longint'($signed(mul_b));

  hilo_mult_unit #(.WL(WL), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .flush(flush), .op_ready(op_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  task automatic chk(input string what, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", cur, what, obs, exp);
    end
  endtask

  task automatic chkb(input string what, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%b expected=%b", cur, what, obs, exp);
    end
  endtask

  // Issue one op from an idle negedge; flush_at=k raises flush for the edge E_k (0 = never).
  task automatic do_op(input logic [1:0] code, input logic [WL-1:0] a, input logic [WL-1:0] b,
                       input int flush_at);
    logic [2*WL-1:0] prod;
    bit is_mul;
    chkb("ready", op_ready, 1'b1);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
    @(negedge clk);
    op_valid = 1'b0;
    is_mul = (code == 2'b00) || (code == 2'b11 && MADD_EN);
    if (!is_mul) begin
      if (code == 2'b01) m_hi = a;
      if (code == 2'b10) m_lo = a;
      chkb("busy", busy, 1'b0);
      chkb("done", done, 1'b0);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      return;
    end
    prod = longint'($signed(a)) * longint'($signed(b));
    chkb("busy0", busy, 1'b1);
    chk("mul_a", mul_a, a);
    chk("mul_b", mul_b, b);
    for (int k = 1; k <= LAT; k++) begin
      if (k == flush_at) flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      if (k == flush_at) begin
        chkb("fl_busy", busy, 1'b0);
        chkb("fl_done", done, 1'b0);
        chk("fl_hi", hi, m_hi);
        chk("fl_lo", lo, m_lo);
        @(negedge clk);
        chkb("fl_done2", done, 1'b0);
        return;
      end
      if (k < LAT) begin
        chkb("busy_mid", busy, 1'b1);
        chkb("done_mid", done, 1'b0);
        chk("mul_a_held", mul_a, a);
      end
    end
    if (code == 2'b00) {m_hi, m_lo} = prod;
    else               {m_hi, m_lo} = {m_hi, m_lo} + prod;
    chkb("busy_end", busy, 1'b0);
    chkb("done", done, 1'b1);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    @(negedge clk);
    chkb("done_off", done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_code = 2'b00; op_a = '0; op_b = '0; flush = 1'b0;
    m_hi = '0; m_lo = '0;
    #2;
    cur = "reset";
    chk("hi", hi, '0);
    chk("lo", lo, '0);
    chkb("busy", busy, 1'b0);
    chkb("done", done, 1'b0);
    chk("mul_a", mul_a, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chkb("ready", op_ready, 1'b1);

    cur = "mult_neg3x7";
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    chk("hi_const", hi, 32'hFFFF_FFFF);
    chk("lo_const", lo, 32'hFFFF_FFEB);

    cur = "mult_min_sq";
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    chk("hi_const", hi, 32'h4000_0000);
    chk("lo_const", lo, 32'h0000_0000);

    // Back-to-back MULTs with op_valid held high.
    cur = "b2b";
    op_valid = 1'b1; op_code = 2'b00; op_a = 32'h0001_0000; op_b = 32'h0001_0000;
    @(negedge clk);
    chkb("e0_ready", op_ready, 1'b0);
    chkb("e0_busy", busy, 1'b1);
    op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    @(negedge clk);
    chkb("e1_ready", op_ready, 1'b0);
    chk("e1_mul_a", mul_a, 32'h0001_0000);
    @(negedge clk);
    chkb("e2_ready", op_ready, 1'b1);
    chkb("e2_done", done, 1'b1);
    chk("e2_hi", hi, 32'h0000_0001);
    chk("e2_lo", lo, 32'h0000_0000);
    @(negedge clk);
    chkb("e3_busy", busy, 1'b1);
    chk("e3_mul_a", mul_a, 32'hFFFF_FFFF);
    op_valid = 1'b0;
    @(negedge clk);
    chkb("e4_busy", busy, 1'b1);
    @(negedge clk);
    chkb("e5_done", done, 1'b1);
    chk("e5_hi", hi, 32'h0000_0000);
    chk("e5_lo", lo, 32'h0000_0001);
    m_hi = 32'h0; m_lo = 32'h1;
    @(negedge clk);
    chkb("e6_done", done, 1'b0);

    cur = "flush_e1";
    do_op(2'b00, 32'd5, 32'd5, 1);
    cur = "mtlo_after_flush";
    do_op(2'b10, 32'h0000_1234, 32'd0, 0);
    chk("lo_const", lo, 32'h0000_1234);
    cur = "flush_on_commit";
    do_op(2'b00, 32'd9, 32'd11, LAT);

    cur = "madd_wrap";
    do_op(2'b01, 32'hFFFF_FFFF, 32'd0, 0);
    do_op(2'b10, 32'hFFFF_FFFF, 32'd0, 0);
    do_op(2'b11, 32'd1, 32'd1, 0);
    chk("hi_const", hi, MADD_EN ? 32'h0 : 32'hFFFF_FFFF);
    chk("lo_const", lo, MADD_EN ? 32'h0 : 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of a multiply.
    cur = "reset_mid_run";
    do_op(2'b01, 32'hA5A5_A5A5, 32'd0, 0);
    op_valid = 1'b1; op_code = 2'b00; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk);
    op_valid = 1'b0;
    chkb("busy_pre", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("hi", hi, '0);
    chk("lo", lo, '0);
    chkb("busy", busy, 1'b0);
    chkb("done", done, 1'b0);
    chk("mul_a", mul_a, '0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chkb("ready_after", op_ready, 1'b1);

    cur = "random";
    for (int i = 0; i < 60; i++) begin
      logic [1:0] c;
      int fa;
      c  = 2'($urandom_range(0, 3));
      fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, LAT)) : 0;
      do_op(c, $urandom, $urandom, fa);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
